// File: rtl/counter_rr_sched_if.sv
// Request/grant bundle between requesters and the counter_rr_sched scheduler.
// Optional hold input is present when COUNTER_RR_SCHED_HOLD_EN is defined.
interface counter_rr_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len_i;
`ifdef COUNTER_RR_SCHED_HOLD_EN
   logic               hold;
`endif
   logic [NREQ-1:0]    gnt;
   logic [CW-1:0]      cnt;
   logic               cnt_en;
   logic [NREQ-1:0]    done;
   logic               busy;

   modport master (
      output req,
      output len_i,
`ifdef COUNTER_RR_SCHED_HOLD_EN
      output hold,
`endif
      input  gnt,
      input  cnt,
      input  cnt_en,
      input  done,
      input  busy
   );

   modport slave (
      input  req,
      input  len_i,
`ifdef COUNTER_RR_SCHED_HOLD_EN
      input  hold,
`endif
      output gnt,
      output cnt,
      output cnt_en,
      output done,
      output busy
   );
endinterface

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Each grant runs cnt from 0 to the requester's terminal count, then pulses done.
// Optional feature macro: COUNTER_RR_SCHED_HOLD_EN (adds a hold input that freezes the run).
module counter_rr_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 8
) (
   input  logic              clk,
   input  logic              rst,
   counter_rr_sched_if.slave bus
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   idx_q;
   logic [CW-1:0]   len_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic            en_q;
   logic            busy_q;

   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic [CW-1:0]   sel_len;
   logic [CW-1:0]   cnt_inc;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
      return NREQ'(1) << i;
   endfunction

   // First requesting index searching upward from ptr+1; lower offsets override higher ones.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr;
      for (int k = int'(NREQ); k >= 1; k--) begin
         if (bus.req[IW'((32'(ptr) + 32'(k)) % NREQ)]) begin
            sel_found = 1'b1;
            sel_idx   = IW'((32'(ptr) + 32'(k)) % NREQ);
         end
      end
      sel_len = bus.len_i[32'(sel_idx)*CW +: CW];
      cnt_inc = CW'(cnt_q + CW'(1));
   end

   // Scheduler FSM; en_q anticipates whether the counter advances in the coming cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= IW'(NREQ - 1);
         idx_q  <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         gnt_q  <= '0;
         done_q <= '0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  idx_q  <= sel_idx;
                  ptr    <= sel_idx;
                  len_q  <= sel_len;
                  cnt_q  <= '0;
                  gnt_q  <= onehot(sel_idx);
                  en_q   <= (sel_len != '0);
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (!bus.req[idx_q]) begin
                  // Aborted run: no done pulse, ptr already sits on the aborted index
                  state  <= IDLE;
                  gnt_q  <= '0;
                  cnt_q  <= '0;
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
`ifdef COUNTER_RR_SCHED_HOLD_EN
               end else if (bus.hold) begin
                  // Frozen: counter, grant and terminal-count check all wait
                  cnt_q <= cnt_q;
`endif
               end else if (cnt_q == len_q) begin
                  state  <= DONE;
                  gnt_q  <= '0;
                  done_q <= onehot(idx_q);
                  en_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
                  en_q  <= (cnt_inc != len_q);
               end
            end
            DONE: begin
               state  <= IDLE;
               cnt_q  <= '0;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               gnt_q  <= '0;
               cnt_q  <= '0;
               en_q   <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.cnt  = cnt_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
`ifdef COUNTER_RR_SCHED_HOLD_EN
   assign bus.cnt_en = en_q & ~bus.hold;
`else
   assign bus.cnt_en = en_q;
`endif

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed testbench for counter_rr_sched (NREQ=4, CW=8).
module tb_counter_rr_sched;
   logic clk;
   logic rst;
   int   total;
   int   passed;

   counter_rr_sched_if #(.NREQ(4), .CW(8)) bus ();

   counter_rr_sched #(.NREQ(4), .CW(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int i, input logic [7:0] v);
      bus.len_i[i*8 +: 8] = v;
   endtask

   initial begin
      logic [3:0] exp_g;
      int         run_cycles;
      total  = 0;
      passed = 0;
      rst       = 1'b1;
      bus.req   = 4'b1111;
      bus.len_i = {8'd1, 8'd1, 8'd1, 8'd1};
`ifdef COUNTER_RR_SCHED_HOLD_EN
      bus.hold  = 1'b0;
`endif

      // Reset held with all requests high
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_gnt",  32'(bus.gnt),  32'h0);
         chk("rst_done", 32'(bus.done), 32'h0);
         chk("rst_cnt",  32'(bus.cnt),  32'h0);
         chk("rst_busy", 32'(bus.busy), 32'h0);
      end
      rst = 1'b0;

      // Round-robin with all len=1: order 0,1,2,3,0 with 4-cycle period
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         tick();
         chk("rr_gnt0",  32'(bus.gnt),    32'(exp_g));
         chk("rr_cnt0",  32'(bus.cnt),    32'h0);
         chk("rr_en0",   32'(bus.cnt_en), 32'h1);
         tick();
         chk("rr_gnt1",  32'(bus.gnt),    32'(exp_g));
         chk("rr_cnt1",  32'(bus.cnt),    32'h1);
         chk("rr_en1",   32'(bus.cnt_en), 32'h0);
         tick();
         chk("rr_done",  32'(bus.done),   32'(exp_g));
         chk("rr_dgnt",  32'(bus.gnt),    32'h0);
         chk("rr_dbusy", 32'(bus.busy),   32'h1);
         tick();
         chk("rr_idle",  32'(bus.busy),   32'h0);
         chk("rr_idone", 32'(bus.done),   32'h0);
         if (g == 4) bus.req = 4'b0000;
      end
      tick();
      chk("rr_quiet", 32'(bus.busy), 32'h0);

      // Single run: requester 2, len=3
      bus.req = 4'b0100;
      set_len(2, 8'd3);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("one_gnt", 32'(bus.gnt),    32'h4);
         chk("one_cnt", 32'(bus.cnt),    32'(c));
         chk("one_en",  32'(bus.cnt_en), (c < 3) ? 32'h1 : 32'h0);
      end
      tick();
      chk("one_done", 32'(bus.done), 32'h4);
      chk("one_dgnt", 32'(bus.gnt),  32'h0);
      bus.req = 4'b0000;
      tick();
      chk("one_busy", 32'(bus.busy), 32'h0);
      chk("one_end",  32'(bus.done), 32'h0);
      chk("one_cnt0", 32'(bus.cnt),  32'h0);

      // Abort: requester 1 drops req at cnt=2
      bus.req = 4'b0010;
      set_len(1, 8'd5);
      tick();
      chk("ab_gnt", 32'(bus.gnt), 32'h2);
      tick();
      tick();
      chk("ab_cnt2", 32'(bus.cnt), 32'h2);
      bus.req = 4'b0000;
      tick();
      chk("ab_gnt0",  32'(bus.gnt),  32'h0);
      chk("ab_cnt0",  32'(bus.cnt),  32'h0);
      chk("ab_busy",  32'(bus.busy), 32'h0);
      chk("ab_ndone", 32'(bus.done), 32'h0);

      // After abort of 1, requester 0 wins over 1; zero-length run
      bus.req = 4'b0011;
      set_len(0, 8'd0);
      tick();
      chk("z_gnt", 32'(bus.gnt),    32'h1);
      chk("z_cnt", 32'(bus.cnt),    32'h0);
      chk("z_en",  32'(bus.cnt_en), 32'h0);
      tick();
      chk("z_done", 32'(bus.done), 32'h1);
      chk("z_dgnt", 32'(bus.gnt),  32'h0);
      bus.req = 4'b0000;
      tick();
      chk("z_idle", 32'(bus.busy), 32'h0);

      // Long run on requester 3, async reset mid-run
      bus.req = 4'b1000;
      set_len(3, 8'd200);
      tick();
      chk("ar_gnt", 32'(bus.gnt), 32'h8);
      for (int c = 0; c < 50; c++) tick();
      chk("ar_cnt50", 32'(bus.cnt), 32'd50);
      chk("ar_en",    32'(bus.cnt_en), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_gnt0",  32'(bus.gnt),    32'h0);
      chk("ar_cnt0",  32'(bus.cnt),    32'h0);
      chk("ar_busy",  32'(bus.busy),   32'h0);
      chk("ar_en0",   32'(bus.cnt_en), 32'h0);
      chk("ar_done",  32'(bus.done),   32'h0);
      #1;
      rst = 1'b0;
      bus.req = 4'b1001;
      set_len(0, 8'd2);
      tick();
      chk("ar_prio0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0000;
      tick();
      chk("ar_abort", 32'(bus.busy), 32'h0);

`ifdef COUNTER_RR_SCHED_HOLD_EN
      // Hold freezes the counter for 3 cycles at cnt=2 on a len=4 run
      bus.req = 4'b0001;
      set_len(0, 8'd4);
      tick();
      tick();
      tick();
      chk("h_cnt2", 32'(bus.cnt), 32'h2);
      bus.hold = 1'b1;
      #1;
      chk("h_en0", 32'(bus.cnt_en), 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("h_frozen", 32'(bus.cnt), 32'h2);
         chk("h_gnt",    32'(bus.gnt), 32'h1);
      end
      bus.hold = 1'b0;
      run_cycles = 6;
      while (bus.gnt != 4'b0000 && run_cycles < 20) begin
         tick();
         if (bus.gnt != 4'b0000) run_cycles++;
      end
      chk("h_runlen", 32'(run_cycles), 32'd8);
      chk("h_done",   32'(bus.done),   32'h1);
      bus.req = 4'b0000;
      tick();
`else
      run_cycles = 0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
